// File: rtl/driver_mon_pkg.sv
// Shared definitions for the driver FIFO-occupancy histogram monitor.
//   mon_state_e  : monitor FSM states
//   BIN_LINEAR / BIN_LOG2 : binning mode selectors
//   clog2_min1   : ceil(log2(n)), never less than 1 (safe as a port width)
package driver_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_DONE = 2'd2
    } mon_state_e;

    localparam int unsigned BIN_LINEAR = 0;
    localparam int unsigned BIN_LOG2   = 1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hist_bin_calc.sv
// Combinational mapping of one FIFO occupancy level to a histogram bin index.
//   level : occupancy sample, LEVEL_W bits
//   bin   : bin index, clamped to NUM_BINS-1
// Linear mode: level / BIN_RANGE. Log2 mode: 0 -> 0, else (MSB index + 1).
module hist_bin_calc
    import driver_mon_pkg::*;
#(
    parameter int unsigned LEVEL_W   = 16,
    parameter int unsigned NUM_BINS  = 16,
    parameter int unsigned BIN_RANGE = 8,
    parameter int unsigned BIN_MODE  = BIN_LINEAR,
    localparam int unsigned BIN_W    = clog2_min1(NUM_BINS)
) (
    input  logic [LEVEL_W-1:0] level,
    output logic [BIN_W-1:0]   bin
);

    localparam int unsigned SHIFT = $clog2(BIN_RANGE);
    // NUM_BINS is a power of two, so NUM_BINS-1 is all ones; truncating it to a
    // narrow LEVEL_W still gives the largest representable index.
    localparam logic [LEVEL_W-1:0] MAX_BIN = LEVEL_W'(NUM_BINS - 1);

    logic [LEVEL_W-1:0] lin_idx;
    logic [LEVEL_W-1:0] log_idx;
    logic [LEVEL_W-1:0] sel_idx;

    always_comb begin
        lin_idx = level >> SHIFT;
        log_idx = '0;
        // Last set bit wins, leaving MSB position + 1.
        for (int i = 0; i < LEVEL_W; i++) begin
            if (level[i]) begin
                log_idx = LEVEL_W'(i + 1);
            end
        end
        sel_idx = (BIN_MODE == BIN_LOG2) ? log_idx : lin_idx;
        bin     = (sel_idx > MAX_BIN) ? BIN_W'(MAX_BIN) : BIN_W'(sel_idx);
    end

endmodule

// File: rtl/driver_hist_monitor.sv
// Multi-channel FIFO-occupancy histogram monitor.
// While in RUN, every cycle each channel's occupancy is binned and the bin's
// saturating counter is incremented; per-channel peak level and a run cycle
// counter are also kept. Results are read through a one-cycle-latency port.
//   clk, reset (async, active high)
//   run_program / end_program : start / stop pulses
//   clear      : synchronous zero of counters, peaks, cycle_cnt, sat_flag
//   fifo_level : packed occupancy, channel c at [c*LEVEL_W +: LEVEL_W]
//   rd_en, rd_ch, rd_bin : read request; rd_bin == NUM_BINS selects the peak
//   rd_data, rd_valid    : read result, one cycle after rd_en
//   active, done         : registered RUN / DONE decodes
//   cycle_cnt            : saturating count of RUN cycles
//   sat_flag             : sticky per-channel "some bin saturated"
module driver_hist_monitor
    import driver_mon_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LEVEL_W   = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned NUM_BINS  = 16,
    parameter int unsigned BIN_RANGE = 8,
    parameter int unsigned BIN_MODE  = BIN_LINEAR,
    localparam int unsigned CH_W     = clog2_min1(NUM_CH),
    localparam int unsigned RD_BIN_W = $clog2(NUM_BINS) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run_program,
    input  logic                      end_program,
    input  logic                      clear,
    input  logic [NUM_CH*LEVEL_W-1:0] fifo_level,
    input  logic                      rd_en,
    input  logic [CH_W-1:0]           rd_ch,
    input  logic [RD_BIN_W-1:0]       rd_bin,
    output logic [CNT_W-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      active,
    output logic                      done,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [NUM_CH-1:0]         sat_flag
);

    localparam int unsigned BIN_W = clog2_min1(NUM_BINS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_e state_q, state_d;
    logic       active_q, done_q;

    logic [CNT_W-1:0]   hist_q [NUM_CH][NUM_BINS];
    logic [LEVEL_W-1:0] peak_q [NUM_CH];
    logic [NUM_CH-1:0]  sat_q;
    logic [CNT_W-1:0]   cycle_q;

    logic [LEVEL_W-1:0] ch_level [NUM_CH];
    logic [BIN_W-1:0]   ch_bin   [NUM_CH];

    logic [CNT_W-1:0] rd_value;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             sample;

    // ------------------------------------------------------------------
    // Per-channel bin mapping
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_level[c] = fifo_level[c*LEVEL_W +: LEVEL_W];

        hist_bin_calc #(
            .LEVEL_W   (LEVEL_W),
            .NUM_BINS  (NUM_BINS),
            .BIN_RANGE (BIN_RANGE),
            .BIN_MODE  (BIN_MODE)
        ) u_bin (
            .level (ch_level[c]),
            .bin   (ch_bin[c])
        );
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            MON_IDLE: begin
                if (run_program) begin
                    state_d = end_program ? MON_DONE : MON_RUN;
                end
            end
            MON_RUN: begin
                if (end_program) begin
                    state_d = MON_DONE;
                end
            end
            MON_DONE: begin
                // Leaving results in place on restart is intentional; clear
                // takes precedence so a clear+run pulse lands in IDLE.
                if (clear) begin
                    state_d = MON_IDLE;
                end else if (run_program && !end_program) begin
                    state_d = MON_RUN;
                end
            end
            default: state_d = MON_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MON_IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == MON_RUN);
            done_q   <= (state_d == MON_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Histogram, peak and cycle counters
    // ------------------------------------------------------------------
    assign sample = (state_q == MON_RUN) && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    hist_q[c][b] <= '0;
                end
                peak_q[c] <= '0;
            end
            sat_q   <= '0;
            cycle_q <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    hist_q[c][b] <= '0;
                end
                peak_q[c] <= '0;
            end
            sat_q   <= '0;
            cycle_q <= '0;
        end else if (sample) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    if (ch_bin[c] == BIN_W'(b)) begin
                        if (hist_q[c][b] == CNT_MAX) begin
                            sat_q[c] <= 1'b1;
                        end else begin
                            hist_q[c][b] <= hist_q[c][b] + CNT_W'(1);
                        end
                    end
                end
                if (ch_level[c] > peak_q[c]) begin
                    peak_q[c] <= ch_level[c];
                end
            end
            if (cycle_q != CNT_MAX) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: selection from the current (pre-increment) state.
    // Unmatched channel/bin selects fall through to zero.
    // ------------------------------------------------------------------
    always_comb begin
        rd_value = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    if (rd_bin == RD_BIN_W'(b)) begin
                        rd_value = hist_q[c][b];
                    end
                end
                if (rd_bin == RD_BIN_W'(NUM_BINS)) begin
                    rd_value = CNT_W'(peak_q[c]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_value;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign active    = active_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_driver_hist_monitor.sv
// Directed bench: three monitor instances (linear default, log2, 4-bit counters)
// share one stimulus stream; each check targets the instance it concerns.
module tb_driver_hist_monitor;

    logic        clk = 1'b0;
    logic        reset, run_program, end_program, clear, rd_en;
    logic [31:0] fifo_level;
    logic [0:0]  rd_ch;
    logic [4:0]  rd_bin;

    logic [15:0] l_rd_data, l_cycle_cnt, g_rd_data, g_cycle_cnt;
    logic [3:0]  s_rd_data, s_cycle_cnt;
    logic        l_rd_valid, l_active, l_done;
    logic        g_rd_valid, g_active, g_done;
    logic        s_rd_valid, s_active, s_done;
    logic [1:0]  l_sat_flag, g_sat_flag, s_sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    driver_hist_monitor u_lin (
        .clk (clk), .reset (reset), .run_program (run_program),
        .end_program (end_program), .clear (clear), .fifo_level (fifo_level),
        .rd_en (rd_en), .rd_ch (rd_ch), .rd_bin (rd_bin), .rd_data (l_rd_data),
        .rd_valid (l_rd_valid), .active (l_active), .done (l_done),
        .cycle_cnt (l_cycle_cnt), .sat_flag (l_sat_flag)
    );

    driver_hist_monitor #(.BIN_MODE (1)) u_log (
        .clk (clk), .reset (reset), .run_program (run_program),
        .end_program (end_program), .clear (clear), .fifo_level (fifo_level),
        .rd_en (rd_en), .rd_ch (rd_ch), .rd_bin (rd_bin), .rd_data (g_rd_data),
        .rd_valid (g_rd_valid), .active (g_active), .done (g_done),
        .cycle_cnt (g_cycle_cnt), .sat_flag (g_sat_flag)
    );

    driver_hist_monitor #(.CNT_W (4)) u_sat (
        .clk (clk), .reset (reset), .run_program (run_program),
        .end_program (end_program), .clear (clear), .fifo_level (fifo_level),
        .rd_en (rd_en), .rd_ch (rd_ch), .rd_bin (rd_bin), .rd_data (s_rd_data),
        .rd_valid (s_rd_valid), .active (s_active), .done (s_done),
        .cycle_cnt (s_cycle_cnt), .sat_flag (s_sat_flag)
    );

    typedef struct {
        int ch;
        int bin;
        int exp_lin;
        int exp_log;
    } rd_vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_levels(input int l0, input int l1);
        fifo_level = {16'(l1), 16'(l0)};
    endtask

    task automatic pulse_run();
        run_program = 1'b1;
        tick();
        run_program = 1'b0;
    endtask

    task automatic pulse_end();
        end_program = 1'b1;
        tick();
        end_program = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic rd_req(input int ch, input int bin);
        rd_en  = 1'b1;
        rd_ch  = 1'(ch);
        rd_bin = 5'(bin);
        tick();
        rd_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t tab[11];
        int      log_lv[5];

        tab[0]  = '{0, 0, 10, 10};
        tab[1]  = '{0, 1, 0, 0};
        tab[2]  = '{0, 15, 0, 0};
        tab[3]  = '{1, 2, 10, 0};
        tab[4]  = '{1, 5, 0, 10};
        tab[5]  = '{1, 0, 0, 0};
        tab[6]  = '{1, 3, 0, 0};
        tab[7]  = '{0, 16, 0, 0};
        tab[8]  = '{0, 17, 0, 0};
        tab[9]  = '{1, 31, 0, 0};
        tab[10] = '{1, 16, 20, 20};
        log_lv  = '{0, 1, 3, 4, 255};

        reset = 1'b1; run_program = 1'b0; end_program = 1'b0; clear = 1'b0;
        rd_en = 1'b0; rd_ch = '0; rd_bin = '0; fifo_level = '0;
        #1;
        chk("reset_active", int'(l_active), 0);
        chk("reset_done", int'(l_done), 0);
        chk("reset_cycle", int'(l_cycle_cnt), 0);
        chk("reset_sat", int'(l_sat_flag), 0);
        chk("reset_rd_valid", int'(l_rd_valid), 0);
        chk("reset_rd_data", int'(l_rd_data), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic linear run: ch0=0, ch1=20 for 10 sampled cycles.
        set_levels(0, 20);
        pulse_run();
        chk("run_active", int'(l_active), 1);
        chk("run_cycle0", int'(l_cycle_cnt), 0);
        repeat (9) tick();
        pulse_end();
        chk("s1_done", int'(l_done), 1);
        chk("s1_active", int'(l_active), 0);
        chk("s1_cycle", int'(l_cycle_cnt), 10);
        chk("s1_log_cycle", int'(g_cycle_cnt), 10);
        for (int i = 0; i < 11; i++) begin
            rd_req(tab[i].ch, tab[i].bin);
            chk($sformatf("tab%0d_lin_valid", i), int'(l_rd_valid), 1);
            chk($sformatf("tab%0d_lin_data", i), int'(l_rd_data), tab[i].exp_lin);
            chk($sformatf("tab%0d_log_data", i), int'(g_rd_data), tab[i].exp_log);
        end
        tick();
        chk("rd_idle_valid", int'(l_rd_valid), 0);
        chk("rd_hold_data", int'(l_rd_data), 20);

        // clear from DONE returns to IDLE and zeroes everything.
        pulse_clear();
        chk("clr_done", int'(l_done), 0);
        chk("clr_active", int'(l_active), 0);
        chk("clr_cycle", int'(l_cycle_cnt), 0);
        rd_req(1, 2);
        chk("clr_bin", int'(l_rd_data), 0);

        // Clamp and peak.
        set_levels(1000, 0);
        pulse_run();
        repeat (4) tick();
        pulse_end();
        chk("clamp_cycle", int'(l_cycle_cnt), 5);
        rd_req(0, 15);
        chk("clamp_lin_bin15", int'(l_rd_data), 5);
        rd_req(0, 10);
        chk("clamp_log_bin10", int'(g_rd_data), 5);
        chk("clamp_lin_bin10", int'(l_rd_data), 0);
        rd_req(0, 16);
        chk("peak_lin", int'(l_rd_data), 1000);
        chk("peak_log", int'(g_rd_data), 1000);
        chk("peak_trunc", int'(s_rd_data), 8);

        // DONE -> RUN keeps accumulated results.
        set_levels(0, 0);
        pulse_run();
        chk("rerun_active", int'(l_active), 1);
        pulse_end();
        chk("rerun_cycle", int'(l_cycle_cnt), 6);
        rd_req(0, 15);
        chk("rerun_bin15", int'(l_rd_data), 5);
        rd_req(0, 0);
        chk("rerun_bin0", int'(l_rd_data), 1);
        pulse_clear();

        // Log2 binning: one cycle per level, end_program on the last.
        pulse_run();
        for (int i = 0; i < 5; i++) begin
            set_levels(log_lv[i], 0);
            end_program = (i == 4);
            tick();
        end
        end_program = 1'b0;
        rd_req(0, 0); chk("log_b0", int'(g_rd_data), 1); chk("lin_b0", int'(l_rd_data), 4);
        rd_req(0, 1); chk("log_b1", int'(g_rd_data), 1);
        rd_req(0, 2); chk("log_b2", int'(g_rd_data), 1);
        rd_req(0, 3); chk("log_b3", int'(g_rd_data), 1);
        rd_req(0, 4); chk("log_b4", int'(g_rd_data), 0);
        rd_req(0, 8); chk("log_b8", int'(g_rd_data), 1);
        rd_req(0, 15); chk("lin_b15", int'(l_rd_data), 1);
        pulse_clear();

        // Saturation on the 4-bit instance: 20 samples of level 0.
        set_levels(0, 0);
        pulse_run();
        repeat (19) tick();
        pulse_end();
        chk("sat_cycle", int'(s_cycle_cnt), 15);
        chk("sat_flag", int'(s_sat_flag), 3);
        chk("nosat_flag", int'(l_sat_flag), 0);
        chk("nosat_cycle", int'(l_cycle_cnt), 20);
        rd_req(0, 0);
        chk("sat_bin0", int'(s_rd_data), 15);
        chk("nosat_bin0", int'(l_rd_data), 20);
        pulse_clear();
        chk("sat_cleared", int'(s_sat_flag), 0);

        // clear during RUN beats the sample; reads return pre-increment values.
        pulse_run();
        repeat (2) tick();
        pulse_clear();
        chk("runclr_cycle", int'(l_cycle_cnt), 0);
        chk("runclr_active", int'(l_active), 1);
        rd_req(0, 0);
        chk("runrd0", int'(l_rd_data), 0);
        chk("runrd0_cycle", int'(l_cycle_cnt), 1);
        tick();
        rd_req(0, 0);
        chk("runrd_pre", int'(l_rd_data), 2);
        pulse_end();
        chk("runrd_cycle", int'(l_cycle_cnt), 4);
        rd_req(0, 0);
        chk("runrd_final", int'(l_rd_data), 4);
        pulse_clear();

        // run_program with end_program from IDLE: straight to DONE, no samples.
        run_program = 1'b1;
        end_program = 1'b1;
        tick();
        run_program = 1'b0;
        end_program = 1'b0;
        chk("both_done", int'(l_done), 1);
        chk("both_active", int'(l_active), 0);
        tick();
        chk("both_cycle", int'(l_cycle_cnt), 0);
        rd_req(0, 0);
        chk("both_bin0", int'(l_rd_data), 0);
        pulse_clear();
        chk("both_clr_done", int'(l_done), 0);

        // Async reset between edges mid-RUN.
        pulse_run();
        repeat (3) tick();
        rd_req(0, 0);
        chk("prerst_rd", int'(l_rd_data), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_active", int'(l_active), 0);
        chk("arst_done", int'(l_done), 0);
        chk("arst_cycle", int'(l_cycle_cnt), 0);
        chk("arst_rd_data", int'(l_rd_data), 0);
        chk("arst_rd_valid", int'(l_rd_valid), 0);
        #1;
        reset = 1'b0;
        tick();
        chk("arst_idle", int'(l_active), 0);
        pulse_run();
        tick();
        pulse_end();
        chk("arst_rerun_cycle", int'(l_cycle_cnt), 2);
        rd_req(0, 0);
        chk("arst_rerun_bin0", int'(l_rd_data), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
